// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through byte FIFO with a valid/ready input.
// Line outputs are registered one cycle behind the FSM, so tx, busy and frame_done stay aligned.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          iCLK,
    input  logic                          RST_n,
    input  logic                          tx_en,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        baud_cnt;
    logic [CW-1:0]        baud_n;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic                 par_bit;
    logic                 par_n;
    logic                 bit_end;
    logic                 can_start;
    logic                 last_stop;
    logic                 line_bit;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    assign din_ready  = (level != FULL_LEVEL);
    assign push       = din_valid & din_ready;
    assign fifo_level = level;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Storage is not reset; only the pointers and level define what is valid.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift;
        par_n     = par_bit;
        pop       = 1'b0;
        last_stop = 1'b0;
        line_bit  = 1'b1;
        bit_end   = (baud_cnt == BAUD_LAST);
        can_start = tx_en && (level != '0);

        if (state != S_IDLE) begin
            baud_n = bit_end ? '0 : baud_cnt + CNT_ONE;
        end

        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                line_bit = 1'b0;
                if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                line_bit = shift[0];
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_cnt + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                line_bit = par_bit;
                if (bit_end) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                line_bit = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        last_stop = 1'b1;
                        // Back-to-back frames: pop straight into START with no idle bit.
                        if (can_start) begin
                            pop     = 1'b1;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + BIT_ONE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_n = mem[rd_ptr];
            par_n   = (PARITY == 2) ? ~(^mem[rd_ptr]) : (^mem[rd_ptr]);
            baud_n  = '0;
            bit_n   = '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!RST_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            tx_q     <= line_bit;
            busy_q   <= (state != S_IDLE);
            done_q   <= last_stop;
        end
    end

endmodule
